// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup, EX-training and statistics bundle of the branch target buffer.
// master = pipeline side, slave = BTB side.
interface branch_target_buffer_if;
    logic [31:0] PCF;
    logic        BranchPredictedF;
    logic [31:0] BranchPredictedTargetF;
    logic        BranchUpdateE;
    logic [31:0] PCE;
    logic        BranchE;
    logic [31:0] BranchTarget;
    logic        BranchPredictedE;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    modport master (
        output PCF, BranchUpdateE, PCE, BranchE, BranchTarget, BranchPredictedE,
        input  BranchPredictedF, BranchPredictedTargetF, BranchCount, MispredictCount
    );

    modport slave (
        input  PCF, BranchUpdateE, PCE, BranchE, BranchTarget, BranchPredictedE,
        output BranchPredictedF, BranchPredictedTargetF, BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational IF lookup, EX-stage training, branch/mispredict counters.
// Define BTB_BHT_EN for 2-bit saturating counters; otherwise a 1-bit (valid = taken) predictor.
module branch_target_buffer #(
    parameter int IDX_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_target_buffer_if.slave bus
);
    localparam int TAG_W   = 30 - IDX_W;
    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
`ifdef BTB_BHT_EN
    logic [1:0]         ctr_q    [ENTRIES];
`endif
    logic [31:0]        bcnt_q, mcnt_q;

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e, pred_f;
    logic             unused_pc_lsb;

    assign idx_f = bus.PCF[IDX_W+1:2];
    assign tag_f = bus.PCF[31:IDX_W+2];
    assign idx_e = bus.PCE[IDX_W+1:2];
    assign tag_e = bus.PCE[31:IDX_W+2];
    assign unused_pc_lsb = ^{bus.PCF[1:0], bus.PCE[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not seen.
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
`ifdef BTB_BHT_EN
    assign pred_f = hit_f && ctr_q[idx_f][1];
`else
    assign pred_f = hit_f;
`endif

    assign bus.BranchPredictedF       = pred_f;
    assign bus.BranchPredictedTargetF = pred_f ? target_q[idx_f] : 32'h0;
    assign bus.BranchCount            = bcnt_q;
    assign bus.MispredictCount        = mcnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
`ifdef BTB_BHT_EN
                ctr_q[i]    <= 2'b00;
`endif
            end
        end else if (bus.BranchUpdateE) begin
            bcnt_q <= bcnt_q + 32'd1;
            if (bus.BranchE != bus.BranchPredictedE)
                mcnt_q <= mcnt_q + 32'd1;
            if (hit_e) begin
                if (bus.BranchE) begin
                    target_q[idx_e] <= bus.BranchTarget;
`ifdef BTB_BHT_EN
                    if (ctr_q[idx_e] != 2'b11)
                        ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
`endif
                end else begin
`ifdef BTB_BHT_EN
                    if (ctr_q[idx_e] != 2'b00)
                        ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
`else
                    valid_q[idx_e] <= 1'b0;
`endif
                end
            end else if (bus.BranchE) begin
                // Taken miss: allocate, evicting any alias at this index.
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= bus.BranchTarget;
`ifdef BTB_BHT_EN
                ctr_q[idx_e]    <= 2'b10;
`endif
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboarded random + directed bench for branch_target_buffer against a map-based model.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_target_buffer_if bus();
    branch_target_buffer #(.IDX_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [23:0] tag;
        logic [31:0] target;
        int          ctr;
    } ent_t;

    typedef struct {
        int          step;
        logic        pred;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    ent_t        model [int];
    exp_t        q [$];
    logic [31:0] m_bc = 0, m_mc = 0;
    bit          armed = 0;
    int          nstep = 0;
    int          checks = 0, passes = 0;

    function automatic void chk(string nm, int st, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s step=%0d got=%h expected=%h", nm, st, got, exp);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        int idx = int'(pc[7:2]);
        return model.exists(idx) && model[idx].tag == pc[31:8];
    endfunction

    task automatic step(input logic r, input logic [31:0] pcf, input logic upd,
                        input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                        input logic pe);
        exp_t e;
        int   ie;
        bit   p;
        rst_n = r;
        bus.PCF = pcf; bus.BranchUpdateE = upd; bus.PCE = pce;
        bus.BranchE = tk; bus.BranchTarget = tgt; bus.BranchPredictedE = pe;
        if (armed) begin
`ifdef BTB_BHT_EN
            p = m_hit(pcf) && model[int'(pcf[7:2])].ctr >= 2;
`else
            p = m_hit(pcf);
`endif
            e.step = nstep; e.pred = p;
            e.tgt = p ? model[int'(pcf[7:2])].target : 32'h0;
            e.bc = m_bc; e.mc = m_mc;
            q.push_back(e);
        end
        @(posedge clk);
        ie = int'(pce[7:2]);
        if (!r) begin
            model.delete(); m_bc = 0; m_mc = 0; armed = 1;
        end else if (upd) begin
            m_bc++;
            if (tk != pe) m_mc++;
            if (m_hit(pce)) begin
                if (tk) begin
                    model[ie].target = tgt;
                    if (model[ie].ctr < 3) model[ie].ctr++;
                end else begin
`ifdef BTB_BHT_EN
                    if (model[ie].ctr > 0) model[ie].ctr--;
`else
                    model.delete(ie);
`endif
                end
            end else if (tk) begin
                model[ie] = '{tag: pce[31:8], target: tgt, ctr: 2};
            end
        end
        nstep++;
        #1;
    endtask

    task automatic look(input logic [31:0] pcf);
        step(1'b1, pcf, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pe);
        step(1'b1, pc, 1'b1, pc, tk, tgt, pe);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pred",   e.step, {31'h0, bus.BranchPredictedF}, {31'h0, e.pred});
                chk("target", e.step, bus.BranchPredictedTargetF, e.tgt);
                chk("bcount", e.step, bus.BranchCount, e.bc);
                chk("mcount", e.step, bus.MispredictCount, e.mc);
            end
        end
    end

    initial begin : stim
        logic [31:0] pa, pb;
        step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        // same-cycle update on empty table, then visible next cycle
        train(32'h100, 1'b1, 32'h180, 1'b0);
        look(32'h100);
        train(32'h100, 1'b0, 32'h0, 1'b1);
        look(32'h100);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        train(32'h100, 1'b1, 32'h180, 1'b0);
        look(32'h100);
        // alias at index 0
        train(32'h100, 1'b1, 32'h180, 1'b1);
        train(32'h100, 1'b1, 32'h180, 1'b1);
        train(32'h200, 1'b1, 32'h300, 1'b0);
        look(32'h100);
        look(32'h200);
        look(32'h203);
        // reset discards a coincident update
        step(1'b0, 32'h200, 1'b1, 32'h400, 1'b1, 32'h500, 1'b0);
        look(32'h400);
        look(32'h200);
        for (int i = 0; i < 600; i++) begin
            pa = ({$urandom_range(0, 3)} << 8) | ({$urandom_range(0, 7)} << 2) | {30'h0, 2'($urandom)};
            pb = ({$urandom_range(0, 3)} << 8) | ({$urandom_range(0, 7)} << 2);
            step(($urandom_range(0, 63) != 0), pb, 1'($urandom_range(0, 3) != 0), pa,
                 1'($urandom), $urandom, 1'($urandom));
        end
        look(32'h0);
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) chk("drain", nstep, q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
